// File: rtl/card_row_sampler.sv
// card_row_sampler: samples one brush bank per card row on sccb rising edges and streams per-column Hollerith codes
// ports: clk, rst_n (async, active-low), sccb/rd_gate (cam timing), brush[COLS], err_clr,
//        out_valid/out_ready/out_col/out_code (column stream), busy, short_err, overrun_err, card_cnt
// define HOLLERITH_CHECK_EN to add the code_err output
module card_row_sampler #(
  parameter int COLS = 80,
  parameter int ROWS = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sccb,
  input  logic            rd_gate,
  input  logic [COLS-1:0] brush,
  input  logic            err_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_col,
  output logic [11:0]     out_code,
  output logic            busy,
  output logic            short_err,
  output logic            overrun_err,
  output logic [15:0]     card_cnt
`ifdef HOLLERITH_CHECK_EN
  ,
  output logic            code_err
`endif
);
  typedef enum logic [1:0] {IDLE, READ, UNLOAD} state_t;
  state_t      state;
  logic [11:0] img [COLS];
  logic [3:0]  row_cnt;
  logic        sccb_q;
  logic        rise;
  logic        last_row;
  logic        short_set;
  logic        ovr_set;
  logic [11:0] col_code;
  assign rise      = sccb & ~sccb_q;
  assign last_row  = row_cnt == 4'(ROWS - 1);
  // a final-row edge coinciding with the gate falling still completes the card
  assign short_set = state == READ && !rd_gate && !(rise && last_row);
  assign ovr_set   = state == UNLOAD && rise;
  assign busy      = state != IDLE;
  always_comb begin
    col_code = '0;
    for (int c = 0; c < COLS; c++)
      if (out_col == 7'(c)) col_code = img[c];
    out_code = out_valid ? col_code : 12'h000;
  end
`ifdef HOLLERITH_CHECK_EN
  // rows 1..9 live in bits 8..0 (row r at bit 9-r), so row 8 is bit 1 and row 9 is bit 0
  always_comb begin
    code_err = out_valid && ((out_code[11] && out_code[10]) ||
               $countones(out_code[8:0]) > 2 ||
               ($countones(out_code[8:0]) == 2 && !(out_code[1] && !out_code[0])));
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= 4'd0;
      sccb_q      <= 1'b0;
      out_valid   <= 1'b0;
      out_col     <= 7'd0;
      card_cnt    <= 16'd0;
      short_err   <= 1'b0;
      overrun_err <= 1'b0;
      for (int c = 0; c < COLS; c++) img[c] <= 12'h000;
    end else begin
      sccb_q      <= sccb;
      short_err   <= short_set | (short_err & ~err_clr);
      overrun_err <= ovr_set | (overrun_err & ~err_clr);
      case (state)
        IDLE: if (rd_gate) begin
          state   <= READ;
          row_cnt <= 4'd0;
          out_col <= 7'd0;
          for (int c = 0; c < COLS; c++) img[c] <= 12'h000;
        end
        READ: begin
          if (rise) begin
            for (int c = 0; c < COLS; c++) img[c][4'd11 - row_cnt] <= brush[c];
            row_cnt <= row_cnt + 4'd1;
          end
          if (rise && last_row) begin
            state     <= UNLOAD;
            out_valid <= 1'b1;
            out_col   <= 7'd0;
          end else if (!rd_gate) state <= IDLE;
        end
        UNLOAD: if (out_ready) begin
          if (out_col == 7'(COLS - 1)) begin
            out_valid <= 1'b0;
            card_cnt  <= card_cnt + 16'd1;
            state     <= IDLE;
          end else out_col <= out_col + 7'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_card_row_sampler.sv
// tb_card_row_sampler: directed scoreboard bench for card_row_sampler with COLS=4
module tb_card_row_sampler;
  localparam int COLS = 4;
  logic            clk = 0, rst_n = 0, sccb = 0, rd_gate = 0, err_clr = 0, out_ready = 0;
  logic [COLS-1:0] brush = '0;
  logic            out_valid, busy, short_err, overrun_err;
  logic [6:0]      out_col;
  logic [11:0]     out_code;
  logic [15:0]     card_cnt;
`ifdef HOLLERITH_CHECK_EN
  logic            code_err;
`endif
  int              errors = 0, checks = 0;
  logic [18:0]     exp_q [$];
  always #5 clk = ~clk;
  card_row_sampler #(.COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .sccb(sccb), .rd_gate(rd_gate), .brush(brush),
    .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_code(out_code), .busy(busy), .short_err(short_err),
    .overrun_err(overrun_err), .card_cnt(card_cnt)
`ifdef HOLLERITH_CHECK_EN
    , .code_err(code_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {13'd0, out_col, out_code}, 32'h7FFFF);
      else chk("word", {13'd0, out_col, out_code}, {13'd0, exp_q.pop_front()});
    end
  task automatic pulse(input logic [COLS-1:0] b, input bit last);
    @(posedge clk); #1 sccb = 1; brush = b;
    if (last) begin @(negedge clk); chk("lat_before", out_valid, 0); end
    @(posedge clk); #1;
    if (last) begin rd_gate = 0; @(negedge clk); chk("lat_after", out_valid, 1); end
    @(posedge clk); #1 sccb = 0; brush = '0;
  endtask
  task automatic run_card(input logic [COLS-1:0][11:0] codes);
    logic [COLS-1:0] b;
    for (int c = 0; c < COLS; c++) exp_q.push_back({7'(c), codes[c]});
    rd_gate = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < COLS; c++) b[c] = codes[c][11-k];
      pulse(b, k == 11);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [COLS-1:0][11:0] rc;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_col", out_col, 0);
    chk("rst_code", out_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short", short_err, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_cnt", card_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    // card 1: row12 + row1 on column 0, held unaccepted
    run_card({12'h000, 12'h000, 12'h000, 12'h900});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_col", out_col, 0);
      chk("hold_code", out_code, 12'h900);
    end
    pulse(4'hF, 0);
    @(negedge clk);
    chk("ovr_flag", overrun_err, 1);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_col", out_col, 0);
    chk("ovr_code", out_code, 12'h900);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0; out_ready = 1;
    for (int i = 0; i < COLS; i++) begin
      @(negedge clk);
      chk("stream_valid", out_valid, 1);
      chk("stream_col", out_col, i);
    end
    @(negedge clk);
    chk("done_valid", out_valid, 0);
    chk("done_cnt", card_cnt, 1);
    chk("done_busy", busy, 0);
    chk("ovr_cleared", overrun_err, 0);
    // short card: gate drops after 7 rows
    @(posedge clk); #1 rd_gate = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) pulse(4'hF, 0);
    rd_gate = 0;
    @(posedge clk);
    @(negedge clk);
    chk("short_flag", short_err, 1);
    chk("short_busy", busy, 0);
    chk("short_valid", out_valid, 0);
    chk("short_cnt", card_cnt, 1);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    @(negedge clk);
    chk("short_cleared", short_err, 0);
    // reset in the middle of a card
    @(posedge clk); #1 rd_gate = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) pulse(4'hF, 0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0; rd_gate = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_code", out_code, 0);
    chk("arst_cnt", card_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    // clean random card streamed with ready held high
    for (int c = 0; c < COLS; c++) rc[c] = 12'($urandom_range(0, 4095));
    run_card(rc);
    for (int i = 0; i < 50 && card_cnt != 16'd1; i++) @(negedge clk);
    chk("rand_cnt", card_cnt, 1);
`ifdef HOLLERITH_CHECK_EN
    out_ready = 0;
    run_card({12'h000, 12'hC00, 12'h0C0, 12'h042});
    for (int c = 0; c < COLS; c++) begin
      @(negedge clk);
      chk("code_err", code_err, (c == 1 || c == 2) ? 1 : 0);
      @(posedge clk); #1 out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
    end
    @(negedge clk);
    chk("code_err_idle", code_err, 0);
`endif
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
